// File: rtl/ahb_master_burst_ctrl.sv
// AHB master burst sequencer: takes one local command, arbitrates for the bus and
// issues the address phases of a SINGLE/INCR/WRAP burst, resuming as INCR after a lost grant.
package ahb_package;
    typedef enum logic [2:0] {
        BURST_SINGLE = 3'd0,
        BURST_INCR   = 3'd1,
        BURST_WRAP4  = 3'd2,
        BURST_INCR4  = 3'd3,
        BURST_WRAP8  = 3'd4,
        BURST_INCR8  = 3'd5,
        BURST_WRAP16 = 3'd6,
        BURST_INCR16 = 3'd7
    } burst_type;

    localparam logic [1:0] HTRANS_IDLE   = 2'd0;
    localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
    localparam logic [1:0] HTRANS_SEQ    = 2'd3;
endpackage

// state   | meaning
// ST_IDLE | waiting for a command, cmd_ready high
// ST_REQ  | bus requested, no address phase driven
// ST_XFER | address phases on the bus, one beat per hwait-free granted cycle
module ahb_master_burst_ctrl
    import ahb_package::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int MAX_LEN    = 16
) (
    input  logic                  hclk,
    input  logic                  hreset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  burst_type             cmd_burst,
    input  logic [4:0]            cmd_len,
    input  logic                  cmd_write,
    input  logic [2:0]            cmd_size,
    output logic                  hreq,
    input  logic                  hgrant,
    input  logic                  hwait,
    output logic [ADDR_WIDTH-1:0] haddr,
    output logic [1:0]            htrans,
    output burst_type             hburst,
    output logic                  hwrite,
    output logic [2:0]            hsize,
    output logic                  done
);
    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_XFER} state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] addr_q, mask_q, next_addr, step, cmd_mask;
    burst_type             burst_q;
    logic                  write_q, first_q, accept, last_beat;
    logic [2:0]            size_q, cmd_size_c;
    logic [4:0]            limit_q, beat_cnt, cmd_limit;

    assign haddr  = addr_q;
    assign hburst = burst_q;
    assign hwrite = write_q;
    assign hsize  = size_q;

    always_comb begin
        cmd_limit = 5'd1;
        case (cmd_burst)
            BURST_INCR: begin
                if (cmd_len == 5'd0)
                    cmd_limit = 5'd1;
                else if (cmd_len > 5'(MAX_LEN))
                    cmd_limit = 5'(MAX_LEN);
                else
                    cmd_limit = cmd_len;
            end
            BURST_WRAP4, BURST_INCR4:   cmd_limit = 5'd4;
            BURST_WRAP8, BURST_INCR8:   cmd_limit = 5'd8;
            BURST_WRAP16, BURST_INCR16: cmd_limit = 5'd16;
            default:                    cmd_limit = 5'd1;
        endcase
        cmd_size_c = (cmd_size > 3'd2) ? 3'd2 : cmd_size;
        // Non-wrapping bursts use an all-ones mask so the wrap formula degenerates to addr+step.
        if (cmd_burst inside {BURST_WRAP4, BURST_WRAP8, BURST_WRAP16})
            cmd_mask = (ADDR_WIDTH'(cmd_limit) << cmd_size_c) - ADDR_WIDTH'(1);
        else
            cmd_mask = '1;
    end

    assign step      = ADDR_WIDTH'(1) << size_q;
    assign next_addr = (addr_q & ~mask_q) | ((addr_q + step) & mask_q);
    assign accept    = (state == ST_XFER) && hgrant && !hwait;
    assign last_beat = (beat_cnt == limit_q - 5'd1);

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        hreq      = 1'b0;
        htrans    = HTRANS_IDLE;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid)
                    state_nxt = ST_REQ;
            end
            ST_REQ: begin
                hreq = 1'b1;
                if (hgrant)
                    state_nxt = ST_XFER;
            end
            ST_XFER: begin
                hreq   = 1'b1;
                htrans = first_q ? HTRANS_NONSEQ : HTRANS_SEQ;
                if (accept && last_beat) begin
                    done      = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (!hgrant && !hwait) begin
                    state_nxt = ST_REQ;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state    <= ST_IDLE;
            addr_q   <= '0;
            mask_q   <= '1;
            burst_q  <= BURST_SINGLE;
            write_q  <= 1'b0;
            size_q   <= 3'd0;
            limit_q  <= 5'd1;
            beat_cnt <= 5'd0;
            first_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        addr_q   <= cmd_addr;
                        mask_q   <= cmd_mask;
                        burst_q  <= cmd_burst;
                        write_q  <= cmd_write;
                        size_q   <= cmd_size_c;
                        limit_q  <= cmd_limit;
                        beat_cnt <= 5'd0;
                    end
                end
                ST_REQ: begin
                    if (hgrant)
                        first_q <= 1'b1;
                end
                ST_XFER: begin
                    if (accept) begin
                        first_q <= 1'b0;
                        if (!last_beat) begin
                            beat_cnt <= beat_cnt + 5'd1;
                            addr_q   <= next_addr;
                        end
                    end else if (!hgrant && !hwait) begin
                        // Lost grant: the remainder is re-issued as an undefined-length burst,
                        // still following the original (possibly wrapped) address order.
                        burst_q <= ((limit_q - beat_cnt) == 5'd1) ? BURST_SINGLE : BURST_INCR;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ahb_master_burst_ctrl.sv
// Scoreboard bench: stimulus pushes the expected address phase for every XFER cycle,
// a negedge monitor pops and compares whenever htrans is non-IDLE.
module tb_ahb_master_burst_ctrl;
    import ahb_package::*;

    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  trans;
        logic [2:0]  burst;
        logic        write;
        logic [2:0]  size;
        logic        done;
    } beat_t;

    logic        hclk = 1'b0;
    logic        hreset, cmd_valid, cmd_ready, cmd_write, hreq, hgrant, hwait, hwrite, done;
    logic [31:0] cmd_addr, haddr;
    burst_type   cmd_burst, hburst;
    logic [4:0]  cmd_len;
    logic [2:0]  cmd_size, hsize;
    logic [1:0]  htrans;

    int    checks   = 0;
    int    failures = 0;
    beat_t exp_q[$];

    always #5 hclk = ~hclk;

    ahb_master_burst_ctrl #(.ADDR_WIDTH(32), .MAX_LEN(16)) dut (
        .hclk(hclk), .hreset(hreset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_burst(cmd_burst), .cmd_len(cmd_len), .cmd_write(cmd_write),
        .cmd_size(cmd_size), .hreq(hreq), .hgrant(hgrant), .hwait(hwait), .haddr(haddr),
        .htrans(htrans), .hburst(hburst), .hwrite(hwrite), .hsize(hsize), .done(done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    always @(negedge hclk) begin
        beat_t act, e;
        if (htrans != HTRANS_IDLE) begin
            act = '{haddr, htrans, hburst, hwrite, hsize, done};
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL beat_unexpected: got %h with empty scoreboard", act);
            end else begin
                e = exp_q.pop_front();
                if (act !== e) begin
                    failures++;
                    $display("FAIL beat: got addr=%h trans=%0d burst=%0d wr=%0b size=%0d done=%0b expected addr=%h trans=%0d burst=%0d wr=%0b size=%0d done=%0b",
                             act.addr, act.trans, act.burst, act.write, act.size, act.done,
                             e.addr, e.trans, e.burst, e.write, e.size, e.done);
                end
            end
            checks++;
            if (hreq !== 1'b1) begin
                failures++;
                $display("FAIL hreq_in_xfer: got %b expected 1", hreq);
            end
        end else if (done !== 1'b0) begin
            failures++;
            $display("FAIL done_outside_xfer: got %b expected 0", done);
        end
    end

    initial begin
        repeat (20000) @(posedge hclk);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic cyc(input logic g, input logic w);
        hgrant = g;
        hwait  = w;
        @(posedge hclk);
        #1;
    endtask

    task automatic start(input logic [31:0] a, input burst_type b, input logic [4:0] l,
                         input logic wr, input logic [2:0] sz);
        chk("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1; cmd_addr = a; cmd_burst = b; cmd_len = l; cmd_write = wr; cmd_size = sz;
        cyc(1'b0, 1'b0);
        cmd_valid = 1'b0;
        chk("req_hreq", {31'd0, hreq}, 32'd1);
        chk("req_htrans", {30'd0, htrans}, 32'd0);
        chk("req_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    endtask

    task automatic bt(input logic [31:0] a, input logic [1:0] t, input burst_type b,
                      input logic wr, input logic [2:0] sz, input logic d,
                      input logic g, input logic w);
        exp_q.push_back('{a, t, b, wr, sz, d});
        cyc(g, w);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
        chk({tag, "_hreq"}, {31'd0, hreq}, 32'd0);
        chk({tag, "_htrans"}, {30'd0, htrans}, 32'd0);
        chk({tag, "_haddr"}, haddr, 32'd0);
        chk({tag, "_hburst"}, {29'd0, hburst}, 32'd0);
        chk({tag, "_hwrite"}, {31'd0, hwrite}, 32'd0);
        chk({tag, "_hsize"}, {29'd0, hsize}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
    endtask

    localparam logic [1:0] N = HTRANS_NONSEQ;
    localparam logic [1:0] S = HTRANS_SEQ;

    initial begin
        logic [31:0] wrap4h [4];
        logic [31:0] wrap16 [16];
        hreset = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_burst = BURST_SINGLE;
        cmd_len = '0; cmd_write = 1'b0; cmd_size = '0; hgrant = 1'b0; hwait = 1'b0;
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        hreset = 1'b0;
        chk_reset_vals("rst");

        // SINGLE write, grant after two REQ cycles
        start(32'h100, BURST_SINGLE, 5'd0, 1'b1, 3'd2);
        cyc(1'b0, 1'b0);
        chk("single_wait_hreq", {31'd0, hreq}, 32'd1);
        cyc(1'b1, 1'b0);
        bt(32'h100, N, BURST_SINGLE, 1'b1, 3'd2, 1'b1, 1'b1, 1'b0);
        chk("single_after_ready", {31'd0, cmd_ready}, 32'd1);
        chk("single_after_hreq", {31'd0, hreq}, 32'd0);

        // WRAP4 from 0x38
        start(32'h38, BURST_WRAP4, 5'd0, 1'b0, 3'd2);
        cyc(1'b1, 1'b0);
        bt(32'h38, N, BURST_WRAP4, 1'b0, 3'd2, 1'b0, 1'b1, 1'b0);
        bt(32'h3C, S, BURST_WRAP4, 1'b0, 3'd2, 1'b0, 1'b1, 1'b0);
        bt(32'h30, S, BURST_WRAP4, 1'b0, 3'd2, 1'b0, 1'b1, 1'b0);
        bt(32'h34, S, BURST_WRAP4, 1'b0, 3'd2, 1'b1, 1'b1, 1'b0);

        // INCR4 with a two-cycle stall on beat 2
        start(32'h200, BURST_INCR4, 5'd0, 1'b1, 3'd2);
        cyc(1'b1, 1'b0);
        bt(32'h200, N, BURST_INCR4, 1'b1, 3'd2, 1'b0, 1'b1, 1'b0);
        bt(32'h204, S, BURST_INCR4, 1'b1, 3'd2, 1'b0, 1'b1, 1'b1);
        bt(32'h204, S, BURST_INCR4, 1'b1, 3'd2, 1'b0, 1'b1, 1'b1);
        bt(32'h204, S, BURST_INCR4, 1'b1, 3'd2, 1'b0, 1'b1, 1'b0);
        bt(32'h208, S, BURST_INCR4, 1'b1, 3'd2, 1'b0, 1'b1, 1'b0);
        bt(32'h20C, S, BURST_INCR4, 1'b1, 3'd2, 1'b1, 1'b1, 1'b0);

        // INCR8 losing grant after three beats, resumed as INCR
        start(32'h0, BURST_INCR8, 5'd0, 1'b0, 3'd2);
        cyc(1'b1, 1'b0);
        bt(32'h0, N, BURST_INCR8, 1'b0, 3'd2, 1'b0, 1'b1, 1'b0);
        bt(32'h4, S, BURST_INCR8, 1'b0, 3'd2, 1'b0, 1'b1, 1'b0);
        bt(32'h8, S, BURST_INCR8, 1'b0, 3'd2, 1'b0, 1'b1, 1'b0);
        bt(32'hC, S, BURST_INCR8, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0);
        chk("regrant_req_hreq", {31'd0, hreq}, 32'd1);
        chk("regrant_req_htrans", {30'd0, htrans}, 32'd0);
        chk("regrant_hburst", {29'd0, hburst}, {29'd0, BURST_INCR});
        cyc(1'b1, 1'b0);
        bt(32'hC, N, BURST_INCR, 1'b0, 3'd2, 1'b0, 1'b1, 1'b0);
        for (int i = 1; i < 5; i++)
            bt(32'hC + 32'(4 * i), S, BURST_INCR, 1'b0, 3'd2, (i == 4), 1'b1, 1'b0);

        // Reset during beat 2 of WRAP8, then a SINGLE read completes
        start(32'h10, BURST_WRAP8, 5'd0, 1'b1, 3'd2);
        cyc(1'b1, 1'b0);
        bt(32'h10, N, BURST_WRAP8, 1'b1, 3'd2, 1'b0, 1'b1, 1'b0);
        hreset = 1'b1;
        bt(32'h14, S, BURST_WRAP8, 1'b1, 3'd2, 1'b0, 1'b1, 1'b0);
        hreset = 1'b0;
        chk_reset_vals("midrst");
        start(32'h40, BURST_SINGLE, 5'd0, 1'b0, 3'd1);
        cyc(1'b1, 1'b0);
        bt(32'h40, N, BURST_SINGLE, 1'b0, 3'd1, 1'b1, 1'b1, 1'b0);

        // INCR length 0 -> one beat
        start(32'h300, BURST_INCR, 5'd0, 1'b0, 3'd2);
        cyc(1'b1, 1'b0);
        bt(32'h300, N, BURST_INCR, 1'b0, 3'd2, 1'b1, 1'b1, 1'b0);

        // INCR length 20 clamped to 16, size 3 clamped to 2
        start(32'h400, BURST_INCR, 5'd20, 1'b1, 3'd3);
        cyc(1'b1, 1'b0);
        for (int i = 0; i < 16; i++)
            bt(32'h400 + 32'(4 * i), (i == 0) ? N : S, BURST_INCR, 1'b1, 3'd2, (i == 15), 1'b1, 1'b0);

        // INCR4 wrapping across the top of the address space
        start(32'hFFFF_FFF8, BURST_INCR4, 5'd0, 1'b0, 3'd2);
        cyc(1'b1, 1'b0);
        bt(32'hFFFF_FFF8, N, BURST_INCR4, 1'b0, 3'd2, 1'b0, 1'b1, 1'b0);
        bt(32'hFFFF_FFFC, S, BURST_INCR4, 1'b0, 3'd2, 1'b0, 1'b1, 1'b0);
        bt(32'h0000_0000, S, BURST_INCR4, 1'b0, 3'd2, 1'b0, 1'b1, 1'b0);
        bt(32'h0000_0004, S, BURST_INCR4, 1'b0, 3'd2, 1'b1, 1'b1, 1'b0);

        // WRAP4 halfword: 8-byte window
        wrap4h = '{32'h46, 32'h40, 32'h42, 32'h44};
        start(32'h46, BURST_WRAP4, 5'd0, 1'b0, 3'd1);
        cyc(1'b1, 1'b0);
        for (int i = 0; i < 4; i++)
            bt(wrap4h[i], (i == 0) ? N : S, BURST_WRAP4, 1'b0, 3'd1, (i == 3), 1'b1, 1'b0);

        // WRAP16 byte: 16-byte window from 0x2E
        for (int i = 0; i < 16; i++)
            wrap16[i] = 32'h20 + ((32'hE + 32'(i)) & 32'hF);
        start(32'h2E, BURST_WRAP16, 5'd0, 1'b1, 3'd0);
        cyc(1'b1, 1'b0);
        for (int i = 0; i < 16; i++)
            bt(wrap16[i], (i == 0) ? N : S, BURST_WRAP16, 1'b1, 3'd0, (i == 15), 1'b1, 1'b0);

        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        chk("final_idle_hreq", {31'd0, hreq}, 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
